axi_lite_stream_bridge: RTL and testbench

//  AXI4-Lite slave front end feeding a compiled stream compute core: registers AR/AW/W, converts byte to word

---
 rtl/axi_lite_stream_bridge_pkg.sv | 20 ++
 rtl/axi_lite_stream_bridge_skid2.sv | 71 +++++++
 rtl/axi_lite_stream_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_axi_lite_stream_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_stream_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_stream_bridge_pkg
// Brief    : Shared response codes, write-tag encodings and address shift
//            for the AXI4-Lite to stream bridge.
// Revision : 1.0 - initial release
// ============================================================================
package axi_lite_stream_bridge_pkg;

    typedef logic [1:0] resp_t;
    typedef logic       tag_t;

    localparam resp_t c_resp_okay   = 2'b00;
    localparam resp_t c_resp_slverr = 2'b10;
    localparam tag_t  c_tag_core    = 1'b0;
    localparam tag_t  c_tag_local   = 1'b1;
    localparam int    c_word_shift  = 2;

endpackage
`default_nettype wire

// File: rtl/axi_lite_stream_bridge_skid2.sv
`default_nettype none
// ============================================================================
// Module   : stream_skid2
// Brief    : Two-entry ready/valid skid buffer with a registered upstream
//            ready and one cycle of latency from input to head.
// Revision : 1.0 - initial release
// ============================================================================
module stream_skid2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] i_data,
    input  logic         i_valid,
    output logic         o_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready
);

    logic [W-1:0] r_mem [2];
    logic         r_wr_ptr;
    logic         r_rd_ptr;
    logic [1:0]   r_count;
    logic         r_ready;
    logic         w_push;
    logic         w_pop;
    logic [1:0]   w_count_nxt;

    assign w_push  = i_valid && r_ready;
    assign w_pop   = o_valid && i_ready;
    assign o_ready = r_ready;
    assign o_valid = (r_count != 2'd0);
    assign o_data  = r_mem[r_rd_ptr];

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + 2'd1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Ready is held low through reset and rises on the first clock after it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
            r_ready  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= !r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= !r_rd_ptr;
            end
            r_count <= w_count_nxt;
            r_ready <= (w_count_nxt != 2'd2);
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_lite_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : axi_lite_stream_bridge
// Brief    : AXI4-Lite slave front end for a stream compute core; buffers
//            AW/W/AR, pairs writes, returns B/R in order.
// Option   : AXI_BRIDGE_STRB_CHECK_EN - partial-strobe writes answered SLVERR
// Revision : 1.0 - initial release
// ============================================================================
module axi_lite_stream_bridge
    import axi_lite_stream_bridge_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 11,
    parameter int MAX_OUT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic [3:0]        s_axi_wstrb,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [ADDR_W-1:0] s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready,
    output logic [ADDR_W-1:0] aw,
    output logic              aw_valid,
    input  logic              aw_ready,
    output logic [DATA_W-1:0] w,
    output logic              w_valid,
    input  logic              w_ready,
    output logic [ADDR_W-1:0] ar,
    output logic              ar_valid,
    input  logic              ar_ready,
    input  logic [DATA_W-1:0] r,
    input  logic              r_valid,
    output logic              r_ready,
    input  logic              b_valid,
    output logic              b_ready
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] c_max_out = CNT_W'(MAX_OUT);

    logic [ADDR_W-1:0]   w_aw_head;
    logic                w_aw_head_valid;
    logic [DATA_W+3:0]   w_w_head;
    logic                w_w_head_valid;
    logic [DATA_W-1:0]   w_w_head_data;
    logic [3:0]          w_w_head_strb;
    logic [ADDR_W-1:0]   w_ar_head;
    logic                w_ar_head_valid;
    logic                w_disp_ok;
    logic                w_strb_bad;
    logic                w_fwd;
    logic                w_aw_done;
    logic                w_w_done;
    logic                w_pair_done;
    logic                w_rd_room;
    logic                w_ar_hs;
    logic                w_r_hs;
    logic                r_aw_sent;
    logic                r_w_sent;
    logic [MAX_OUT-1:0]  r_tag_mem;
    logic [PTR_W-1:0]    r_tag_wr;
    logic [PTR_W-1:0]    r_tag_rd;
    logic [CNT_W-1:0]    r_tag_cnt;
    logic                w_tag_empty;
    logic                w_tag_full;
    tag_t                w_tag_head;
    logic                w_tag_pop;
    logic [CNT_W-1:0]    r_rd_cnt;

    stream_skid2 #(.W(ADDR_W)) u_aw_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (s_axi_awaddr),
        .i_valid (s_axi_awvalid),
        .o_ready (s_axi_awready),
        .o_data  (w_aw_head),
        .o_valid (w_aw_head_valid),
        .i_ready (w_pair_done)
    );

    stream_skid2 #(.W(DATA_W + 4)) u_w_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  ({s_axi_wstrb, s_axi_wdata}),
        .i_valid (s_axi_wvalid),
        .o_ready (s_axi_wready),
        .o_data  (w_w_head),
        .o_valid (w_w_head_valid),
        .i_ready (w_pair_done)
    );

    stream_skid2 #(.W(ADDR_W)) u_ar_skid (
        .clk     (clk),
        .rst     (rst),
        .i_data  (s_axi_araddr),
        .i_valid (s_axi_arvalid),
        .o_ready (s_axi_arready),
        .o_data  (w_ar_head),
        .o_valid (w_ar_head_valid),
        .i_ready (ar_ready && w_rd_room)
    );

    assign w_w_head_data = w_w_head[DATA_W-1:0];
    assign w_w_head_strb = w_w_head[DATA_W+3:DATA_W];

`ifdef AXI_BRIDGE_STRB_CHECK_EN
    assign w_strb_bad = (w_w_head_strb != 4'hF);
`else
    logic w_unused_strb;
    assign w_unused_strb = ^w_w_head_strb;
    assign w_strb_bad    = 1'b0;
`endif

    // A pair is complete once each half has been taken, in any cycle order.
    assign w_disp_ok   = w_aw_head_valid && w_w_head_valid && !w_tag_full;
    assign w_fwd       = w_disp_ok && !w_strb_bad;
    assign aw_valid    = w_fwd && !r_aw_sent;
    assign w_valid     = w_fwd && !r_w_sent;
    assign aw          = w_aw_head >> c_word_shift;
    assign w           = w_w_head_data;
    assign w_aw_done   = r_aw_sent || (aw_valid && aw_ready);
    assign w_w_done    = r_w_sent || (w_valid && w_ready);
    assign w_pair_done = (w_fwd && w_aw_done && w_w_done) || (w_disp_ok && w_strb_bad);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_aw_sent <= 1'b0;
            r_w_sent  <= 1'b0;
        end else if (w_pair_done) begin
            r_aw_sent <= 1'b0;
            r_w_sent  <= 1'b0;
        end else begin
            if (aw_valid && aw_ready) begin
                r_aw_sent <= 1'b1;
            end
            if (w_valid && w_ready) begin
                r_w_sent <= 1'b1;
            end
        end
    end

    assign w_tag_empty = (r_tag_cnt == '0);
    assign w_tag_full  = (r_tag_cnt == c_max_out);
    assign w_tag_head  = r_tag_mem[r_tag_rd];
    assign s_axi_bvalid = !w_tag_empty && ((w_tag_head == c_tag_local) || b_valid);
    assign b_ready      = !w_tag_empty && (w_tag_head == c_tag_core) && s_axi_bready;
    assign s_axi_bresp  = (!w_tag_empty && (w_tag_head == c_tag_local)) ? c_resp_slverr : c_resp_okay;
    assign w_tag_pop    = s_axi_bvalid && s_axi_bready;

    always_ff @(posedge clk) begin
        if (w_pair_done) begin
            r_tag_mem[r_tag_wr] <= w_strb_bad ? c_tag_local : c_tag_core;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tag_wr  <= '0;
            r_tag_rd  <= '0;
            r_tag_cnt <= '0;
        end else begin
            if (w_pair_done) begin
                r_tag_wr <= r_tag_wr + PTR_W'(1);
            end
            if (w_tag_pop) begin
                r_tag_rd <= r_tag_rd + PTR_W'(1);
            end
            if (w_pair_done && !w_tag_pop) begin
                r_tag_cnt <= r_tag_cnt + CNT_W'(1);
            end else if (!w_pair_done && w_tag_pop) begin
                r_tag_cnt <= r_tag_cnt - CNT_W'(1);
            end
        end
    end

    assign w_rd_room    = (r_rd_cnt < c_max_out);
    assign ar_valid     = w_ar_head_valid && w_rd_room;
    assign ar           = w_ar_head >> c_word_shift;
    assign s_axi_rvalid = r_valid;
    assign s_axi_rdata  = r;
    assign s_axi_rresp  = c_resp_okay;
    assign r_ready      = s_axi_rready;
    assign w_ar_hs      = ar_valid && ar_ready;
    assign w_r_hs       = r_valid && s_axi_rready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_cnt <= '0;
        end else if (w_ar_hs && !w_r_hs) begin
            r_rd_cnt <= r_rd_cnt + CNT_W'(1);
        end else if (!w_ar_hs && w_r_hs) begin
            r_rd_cnt <= r_rd_cnt - CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_lite_stream_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_lite_stream_bridge
// Brief    : Directed bench for the AXI4-Lite to stream bridge with a small
//            AXI master and stream core model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_lite_stream_bridge;

    localparam int DATA_W  = 32;
    localparam int ADDR_W  = 11;
    localparam int MAX_OUT = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [ADDR_W-1:0] s_axi_awaddr = '0;
    logic              s_axi_awvalid = 1'b0;
    logic              s_axi_awready;
    logic [DATA_W-1:0] s_axi_wdata = '0;
    logic [3:0]        s_axi_wstrb = '0;
    logic              s_axi_wvalid = 1'b0;
    logic              s_axi_wready;
    logic [1:0]        s_axi_bresp;
    logic              s_axi_bvalid;
    logic              s_axi_bready = 1'b0;
    logic [ADDR_W-1:0] s_axi_araddr = '0;
    logic              s_axi_arvalid = 1'b0;
    logic              s_axi_arready;
    logic [DATA_W-1:0] s_axi_rdata;
    logic [1:0]        s_axi_rresp;
    logic              s_axi_rvalid;
    logic              s_axi_rready = 1'b0;
    logic [ADDR_W-1:0] aw;
    logic              aw_valid;
    logic              aw_ready = 1'b0;
    logic [DATA_W-1:0] w;
    logic              w_valid;
    logic              w_ready = 1'b0;
    logic [ADDR_W-1:0] ar;
    logic              ar_valid;
    logic              ar_ready = 1'b0;
    logic [DATA_W-1:0] r = '0;
    logic              r_valid = 1'b0;
    logic              r_ready;
    logic              b_valid = 1'b0;
    logic              b_ready;

    always #5 clk = ~clk;

    axi_lite_stream_bridge #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wvalid(s_axi_wvalid),
        .s_axi_wready(s_axi_wready), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
        .s_axi_bready(s_axi_bready), .s_axi_araddr(s_axi_araddr), .s_axi_arvalid(s_axi_arvalid),
        .s_axi_arready(s_axi_arready), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .aw(aw), .aw_valid(aw_valid), .aw_ready(aw_ready),
        .w(w), .w_valid(w_valid), .w_ready(w_ready),
        .ar(ar), .ar_valid(ar_valid), .ar_ready(ar_ready),
        .r(r), .r_valid(r_valid), .r_ready(r_ready),
        .b_valid(b_valid), .b_ready(b_ready)
    );

    int checks = 0;
    int errors = 0;

    // master-side pending beats and knobs
    logic [ADDR_W-1:0] q_aw[$];
    logic [ADDR_W-1:0] q_ar[$];
    logic [35:0]       q_w[$];
    bit                m_aw_en = 1'b1;
    int                rready_mode = 0;   // 0 low, 1 high, 2 toggle
    // core-side knobs and state
    bit                c_aw_rdy = 1'b1;
    bit                c_w_rdy = 1'b1;
    bit                c_ar_rdy = 1'b1;
    bit                c_b_en = 1'b1;
    bit                c_r_en = 1'b1;
    int                n_core_aw = 0;
    int                n_core_w = 0;
    int                n_core_b = 0;
    logic [31:0]       r_q[$];
    int                rd_out = 0;
    int                rd_out_max = 0;
    int                ar_at_limit = 0;
    int                cyc = 0;
    // observations
    logic [ADDR_W-1:0] obs_aw[$];
    logic [ADDR_W-1:0] obs_ar[$];
    logic [31:0]       obs_w[$];
    logic [31:0]       obs_r[$];
    logic [1:0]        obs_b[$];

    initial begin
        forever begin
            @(negedge clk);
            #1;
            cyc++;
            s_axi_awvalid = m_aw_en && (q_aw.size() > 0);
            s_axi_awaddr  = (q_aw.size() > 0) ? q_aw[0] : '0;
            s_axi_wvalid  = (q_w.size() > 0);
            {s_axi_wstrb, s_axi_wdata} = (q_w.size() > 0) ? q_w[0] : 36'h0;
            s_axi_arvalid = (q_ar.size() > 0);
            s_axi_araddr  = (q_ar.size() > 0) ? q_ar[0] : '0;
            s_axi_bready  = !rst;
            s_axi_rready  = (rready_mode == 2) ? cyc[0] : (rready_mode == 1);
            aw_ready      = c_aw_rdy;
            w_ready       = c_w_rdy;
            ar_ready      = c_ar_rdy;
            b_valid       = c_b_en && (((n_core_aw < n_core_w) ? n_core_aw : n_core_w) > n_core_b);
            r_valid       = c_r_en && (r_q.size() > 0);
            r             = (r_q.size() > 0) ? r_q[0] : '0;
            #1;
            if (ar_valid && rd_out >= MAX_OUT) ar_at_limit++;
            if (s_axi_awvalid && s_axi_awready) void'(q_aw.pop_front());
            if (s_axi_wvalid && s_axi_wready) void'(q_w.pop_front());
            if (s_axi_arvalid && s_axi_arready) void'(q_ar.pop_front());
            if (aw_valid && aw_ready) begin obs_aw.push_back(aw); n_core_aw++; end
            if (w_valid && w_ready) begin obs_w.push_back(w); n_core_w++; end
            if (ar_valid && ar_ready) begin
                obs_ar.push_back(ar);
                r_q.push_back(32'hC0DE0000 | 32'(ar));
                rd_out++;
            end
            if (b_valid && b_ready) n_core_b++;
            if (s_axi_bvalid && s_axi_bready) obs_b.push_back(s_axi_bresp);
            if (r_valid && r_ready) begin void'(r_q.pop_front()); rd_out--; end
            if (s_axi_rvalid && s_axi_rready) obs_r.push_back(s_axi_rdata);
            if (rd_out > rd_out_max) rd_out_max = rd_out;
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_b(input int n, input string nm);
        int k = 0;
        while (obs_b.size() < n && k < 300) begin @(negedge clk); k++; end
        check({nm, "_b_arrived"}, 32'(obs_b.size() >= n), 32'd1);
    endtask

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        strb;
        bit                fwd;
        logic [ADDR_W-1:0] exp_aw;
        logic [1:0]        exp_resp;
    } wvec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ADDR_W-1:0] exp_ar;
        logic [31:0]       exp_data;
    } rvec_t;

    wvec_t wv[6];
    rvec_t rv[8];

    initial begin
        int na, nw, nb, nr, k;
        logic [1:0] exp_mid;
        wv[0] = '{11'h010, 32'hDEADBEEF, 4'hF, 1'b1, 11'h004, 2'b00};
        wv[1] = '{11'h7FC, 32'h12345678, 4'hF, 1'b1, 11'h1FF, 2'b00};
        wv[2] = '{11'h003, 32'h00000001, 4'hF, 1'b1, 11'h000, 2'b00};
        wv[3] = '{11'h404, 32'hA5A55A5A, 4'hF, 1'b1, 11'h101, 2'b00};
`ifdef AXI_BRIDGE_STRB_CHECK_EN
        wv[4] = '{11'h020, 32'h0BAD0BAD, 4'h3, 1'b0, 11'h008, 2'b10};
        exp_mid = 2'b10;
`else
        wv[4] = '{11'h020, 32'h0BAD0BAD, 4'h3, 1'b1, 11'h008, 2'b00};
        exp_mid = 2'b00;
`endif
        wv[5] = '{11'h7FF, 32'hFFFFFFFF, 4'hF, 1'b1, 11'h1FF, 2'b00};
        rv[0] = '{11'h000, 11'h000, 32'hC0DE0000};
        rv[1] = '{11'h004, 11'h001, 32'hC0DE0001};
        rv[2] = '{11'h008, 11'h002, 32'hC0DE0002};
        rv[3] = '{11'h00C, 11'h003, 32'hC0DE0003};
        rv[4] = '{11'h010, 11'h004, 32'hC0DE0004};
        rv[5] = '{11'h014, 11'h005, 32'hC0DE0005};
        rv[6] = '{11'h7FF, 11'h1FF, 32'hC0DE01FF};
        rv[7] = '{11'h402, 11'h100, 32'hC0DE0100};

        // reset state
        tick(3);
        #3;
        check("reset_readys", 32'({s_axi_awready, s_axi_wready, s_axi_arready, b_ready, r_ready}), 32'd0);
        check("reset_valids", 32'({s_axi_bvalid, s_axi_rvalid, aw_valid, w_valid, ar_valid}), 32'd0);
        check("reset_resps", 32'({s_axi_bresp, s_axi_rresp}), 32'd0);
        rst = 1'b0;
        tick(1);
        check("ready_after_reset", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'd7);

        // single writes from the table
        for (int i = 0; i < 6; i++) begin
            na = obs_aw.size(); nw = obs_w.size(); nb = obs_b.size();
            q_aw.push_back(wv[i].addr);
            q_w.push_back({wv[i].strb, wv[i].data});
            wait_b(nb + 1, $sformatf("wvec%0d", i));
            tick(2);
            check($sformatf("wvec%0d_aw_count", i), 32'(obs_aw.size() - na), 32'(wv[i].fwd));
            if (wv[i].fwd) begin
                check($sformatf("wvec%0d_aw", i), 32'((obs_aw.size() > na) ? obs_aw[na] : 'x), 32'(wv[i].exp_aw));
                check($sformatf("wvec%0d_w", i), (obs_w.size() > nw) ? obs_w[nw] : 'x, wv[i].data);
            end
            check($sformatf("wvec%0d_bresp", i), 32'((obs_b.size() > nb) ? obs_b[nb] : 'x), 32'(wv[i].exp_resp));
        end

        // W three cycles ahead of AW, core holds aw_ready low after taking w
        na = obs_aw.size(); nw = obs_w.size(); nb = obs_b.size();
        c_aw_rdy = 1'b0; m_aw_en = 1'b0;
        q_w.push_back({4'hF, 32'h0F0F0F0F});
        q_aw.push_back(11'h044);
        tick(3);
        m_aw_en = 1'b1;
        k = 0;
        while (obs_w.size() == nw && k < 50) begin tick(1); k++; end
        tick(2);
        c_aw_rdy = 1'b1;
        wait_b(nb + 1, "split");
        tick(4);
        check("split_w_count", 32'(obs_w.size() - nw), 32'd1);
        check("split_aw_count", 32'(obs_aw.size() - na), 32'd1);
        check("split_b_count", 32'(obs_b.size() - nb), 32'd1);
        check("split_aw", 32'((obs_aw.size() > na) ? obs_aw[na] : 'x), 32'h11);

        // MAX_OUT+2 writes with core acks held off
        na = obs_aw.size(); nb = obs_b.size();
        c_b_en = 1'b0;
        for (int i = 0; i < MAX_OUT + 2; i++) begin
            q_aw.push_back(11'(11'h100 + 4 * i));
            q_w.push_back({4'hF, 32'(i)});
        end
        tick(25);
        check("limit_pairs", 32'(obs_aw.size() - na), 32'(MAX_OUT));
        check("limit_awready", 32'({s_axi_awready, s_axi_wready}), 32'd0);
        c_b_en = 1'b1;
        wait_b(nb + MAX_OUT + 2, "limit");
        tick(3);
        check("limit_b_count", 32'(obs_b.size() - nb), 32'(MAX_OUT + 2));
        for (int i = 0; i < MAX_OUT + 2; i++) begin
            check($sformatf("limit_aw%0d", i), 32'((obs_aw.size() > na + i) ? obs_aw[na + i] : 'x), 32'(11'h040 + i));
        end

        // strobe mix F, 3, F back to back
        na = obs_aw.size(); nb = obs_b.size();
        q_aw.push_back(11'h030); q_w.push_back({4'hF, 32'h11111111});
        q_aw.push_back(11'h034); q_w.push_back({4'h3, 32'h22222222});
        q_aw.push_back(11'h038); q_w.push_back({4'hF, 32'h33333333});
        wait_b(nb + 3, "strb");
        tick(3);
        check("strb_pairs", 32'(obs_aw.size() - na), (exp_mid == 2'b10) ? 32'd2 : 32'd3);
        check("strb_bresp", 32'((obs_b.size() >= nb + 3) ? {obs_b[nb], obs_b[nb + 1], obs_b[nb + 2]} : 'x),
              32'({2'b00, exp_mid, 2'b00}));

        // reads, limited by outstanding count, then drained with toggling rready
        nr = obs_r.size(); na = obs_ar.size();
        c_r_en = 1'b0;
        for (int i = 0; i < 8; i++) q_ar.push_back(rv[i].addr);
        tick(15);
        check("rd_stall_ar_count", 32'(obs_ar.size() - na), 32'(MAX_OUT));
        check("rd_stall_ar_valid", 32'(ar_valid), 32'd0);
        c_r_en = 1'b1; rready_mode = 2;
        k = 0;
        while (obs_r.size() < nr + 8 && k < 300) begin tick(1); k++; end
        check("rd_all_arrived", 32'(obs_r.size() - nr), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("rvec%0d_ar", i), 32'((obs_ar.size() > na + i) ? obs_ar[na + i] : 'x), 32'(rv[i].exp_ar));
            check($sformatf("rvec%0d_rdata", i), (obs_r.size() > nr + i) ? obs_r[nr + i] : 'x, rv[i].exp_data);
        end
        check("rd_out_max", 32'(rd_out_max), 32'(MAX_OUT));
        check("ar_valid_at_limit", 32'(ar_at_limit), 32'd0);
        rready_mode = 0;

        // reset with two writes and one read outstanding at the core
        c_b_en = 1'b0; c_r_en = 1'b0;
        na = obs_aw.size();
        q_aw.push_back(11'h050); q_w.push_back({4'hF, 32'hAAAA0001});
        q_aw.push_back(11'h054); q_w.push_back({4'hF, 32'hAAAA0002});
        q_ar.push_back(11'h060);
        tick(10);
        check("pre_rst_pairs", 32'(obs_aw.size() - na), 32'd2);
        check("pre_rst_bvalid", 32'(s_axi_bvalid), 32'd0);
        rst = 1'b1;
        q_aw.delete(); q_w.delete(); q_ar.delete(); r_q.delete();
        rd_out = 0; n_core_aw = 0; n_core_w = 0; n_core_b = 0;
        tick(1);
        #3;
        check("rst_valids", 32'({s_axi_bvalid, aw_valid, w_valid, ar_valid, s_axi_awready}), 32'd0);
        tick(1);
        rst = 1'b0;
        c_b_en = 1'b1; c_r_en = 1'b1;
        tick(2);
        na = obs_aw.size(); nb = obs_b.size();
        q_aw.push_back(11'h0A8); q_w.push_back({4'hF, 32'h600D600D});
        wait_b(nb + 1, "post_rst");
        tick(6);
        check("post_rst_b_count", 32'(obs_b.size() - nb), 32'd1);
        check("post_rst_bresp", 32'((obs_b.size() > nb) ? obs_b[nb] : 'x), 32'd0);
        check("post_rst_aw", 32'((obs_aw.size() > na) ? obs_aw[na] : 'x), 32'h2A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
